obi_reg_bridge: RTL



---
 rtl/obi_reg_bridge.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/obi_reg_bridge.sv
// OBI subordinate to regbus bridge: one outstanding access, in-order response.
// Optional regbus wait timeout: define OBI_REG_BRIDGE_TIMEOUT_EN.
package croc_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    sbr_obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module obi_reg_bridge
  import croc_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i
);

  typedef enum logic [1:0] {IDLE, REG, RSP} state_t;

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic                   we_q;
  logic [DataWidth/8-1:0] be_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [IdWidth-1:0]     aid_q;
  logic [DataWidth-1:0]   rdata_q;
  logic                   err_q;

  logic                   gnt, latch, capture, cap_err;
  logic [DataWidth-1:0]   cap_rdata;

  logic unused_a_optional;
  assign unused_a_optional = obi_req_i.a.a_optional;

`ifdef OBI_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  cnt_q <= '0;
    else if (latch)                               cnt_q <= '0;
    else if (state_q == REG && !reg_rsp_i.ready)  cnt_q <= cnt_q + 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt       = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    cap_err   = 1'b0;
    cap_rdata = '0;
    case (state_q)
      IDLE: begin
        gnt = obi_req_i.req;
        if (obi_req_i.req) begin
          latch   = 1'b1;
          state_d = REG;
        end
      end
      REG: begin
        // A ready in the timeout cycle still completes normally.
        if (reg_rsp_i.ready) begin
          capture   = 1'b1;
          cap_rdata = we_q ? '0 : reg_rsp_i.rdata;
          cap_err   = reg_rsp_i.error;
          state_d   = RSP;
        end
`ifdef OBI_REG_BRIDGE_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          capture = 1'b1;
          cap_err = 1'b1;
          state_d = RSP;
        end
`endif
      end
      RSP: begin
        gnt = obi_req_i.req;
        if (obi_req_i.req) begin
          latch   = 1'b1;
          state_d = REG;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q  <= obi_req_i.a.addr;
        we_q    <= obi_req_i.a.we;
        be_q    <= obi_req_i.a.be;
        wdata_q <= obi_req_i.a.wdata;
        aid_q   <= obi_req_i.a.aid;
      end
      if (capture) begin
        rdata_q <= cap_rdata;
        err_q   <= cap_err;
      end
    end
  end

  // Regbus side is driven only from latched state so it stays stable until ready.
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = we_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = be_q;
    reg_req_o.valid = (state_q == REG);
  end

  always_comb begin
    obi_rsp_o          = '0;
    obi_rsp_o.gnt      = gnt;
    obi_rsp_o.rvalid   = (state_q == RSP);
    obi_rsp_o.r.rdata  = rdata_q;
    obi_rsp_o.r.rid    = aid_q;
    obi_rsp_o.r.err    = err_q;
  end

endmodule
